mips_decode_execute: RTL and testbench
======================================

Name: mips_decode_execute

Overview:
- Single-cycle MIPS decode + execute slice for the processor datapath.
- Decodes a 32-bit instruction into register addresses, immediate/jump fields and control strobes.
- Drives a 32-bit ALU with a zero flag from register operands or the extended immediate.
- Registers the execute result once per clock for downstream writeback/observation.

Parameters:
none (datapath fixed at 32 bits, register addresses 5 bits)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
instruction  input  32  current instruction word
data_a  input  32  register read port A value (rs)
data_b  input  32  register read port B value (rt)
addr_a  output  5  rs field, instr[25:21]
addr_b  output  5  rt field, instr[20:16]
addr_in  output  5  write register: rd (instr[15:11]) for R-type, rt for I-type writers
shamt  output  5  instr[10:6]
imm16  output  16  instr[15:0]
addr26  output  26  instr[25:0]
reg_write  output  1  instruction writes a register
mem_read  output  1  lw
mem_write  output  1  sw
is_branch  output  1  beq or bne
is_jump  output  1  j
illegal  output  1  unrecognised opcode/funct
alu_op  output  3  selected ALU operation
alu_out  output  32  combinational ALU result
alu_zout  output  1  combinational: alu_out == 0
branch_taken  output  1  (beq & zout) | (bne & ~zout)
result_q  output  32  alu_out registered
zero_q  output  1  alu_zout registered
reg_write_q  output  1  reg_write registered
addr_in_q  output  5  addr_in registered

Behaviour:
- Field extraction is purely combinational; field outputs track the instruction for every opcode.
- Control, ALU, alu_zout and branch_taken are combinational, with no cycle of latency.
- ALU operations (alu_op):
  - 000 AND
  - 001 OR
  - 010 ADD (wrapping mod 2^32, no overflow trap)
  - 011 SLL: data_b << shamt
  - 100 SRL: data_b >> shamt, logical
  - 101 NOR
  - 110 SUB (wrapping)
  - 111 SLT: signed compare, result 1 or 0
- Operand selection:
  - in1 = data_a.
  - in2 = data_b for R-type, beq and bne.
  - Otherwise in2 = extended imm16.
  - Zero-extend for andi and ori; sign-extend for all other immediate instructions.
- R-type decode (opcode 0x00), by funct:
  - 0x20 add→010
  - 0x22 sub→110
  - 0x24 and→000
  - 0x25 or→001
  - 0x27 nor→101
  - 0x2A slt→111
  - 0x00 sll→011
  - 0x02 srl→100
  - All valid R-type funct codes set reg_write=1, with addr_in=rd.
- I-type decode, by opcode:
  - 0x08 addi→ADD
  - 0x0C andi→AND
  - 0x0D ori→OR
  - 0x0A slti→SLT
  - 0x23 lw→ADD, mem_read
  - 0x2B sw→ADD, mem_write
  - 0x04 beq→SUB, is_branch
  - 0x05 bne→SUB, is_branch
- I-type register write:
  - addi, andi, ori, slti and lw set reg_write=1, with addr_in=rt.
  - sw, beq and bne set reg_write=0.
- J-type: opcode 0x02 j sets is_jump=1, with no write and no memory access.
- Illegal opcode/funct:
  - illegal=1.
  - reg_write, mem_read, mem_write, is_branch and is_jump all 0.
  - alu_op=010.
- Registered stage:
  - On each rising clk, result_q/zero_q/reg_write_q/addr_in_q capture their combinational sources.
  - No enable.
- Reset:
  - rst_n low immediately (asynchronously) forces result_q=0, zero_q=0, reg_write_q=0, addr_in_q=0.
  - Held while low; the first capture is at the first rising clk after rst_n deasserts.
  - Combinational outputs are unaffected by reset.
- Write to $zero:
  - An rd or rt of 0 is passed through unchanged.
  - Suppressing writes to register 0 is the register file's job.

Test Plan:
- add: instruction 0x00221820 (add $3,$1,$2), data_a=5, data_b=7.
  - alu_out=12, addr_in=3, reg_write=1.
  - After next clk: result_q=12, addr_in_q=3.
- sub/beq: beq with data_a=data_b=0x1234 gives alu_zout=1, branch_taken=1, reg_write=0.
  - bne with the same operands gives branch_taken=0.
- Extension:
  - addi imm16=0xFFFF, data_a=1 → alu_out=0.
  - ori imm16=0xFFFF, data_a=0 → alu_out=0x0000FFFF.
- slt/shift:
  - slt data_a=0xFFFFFFFF, data_b=1 → 1.
  - sll data_b=1, shamt=31 → 0x80000000.
  - srl data_b=0x80000000, shamt=31 → 1.
- Jump/memory/illegal:
  - 0x08000010 → is_jump=1, addr26=0x10.
  - lw → mem_read=1, addr_in=rt.
  - Opcode 0x3F → illegal=1, all strobes 0.
- Reset: drive rst_n low mid-cycle after result_q=12.
  - result_q=0 and reg_write_q=0 immediately, without waiting for clk.
  - Values held through clk edges while low; capture resumes after release.

Source files
------------

// File: rtl/mips_decode_execute.sv
// Single-cycle MIPS decode + execute slice.
// Splits the instruction into its fields, derives the control strobes, runs
// the 32-bit ALU on register or immediate operands, and registers the result.
module mips_decode_execute (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    output logic [4:0]  addr_a,
    output logic [4:0]  addr_b,
    output logic [4:0]  addr_in,
    output logic [4:0]  shamt,
    output logic [15:0] imm16,
    output logic [25:0] addr26,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        is_branch,
    output logic        is_jump,
    output logic        illegal,
    output logic [2:0]  alu_op,
    output logic [31:0] alu_out,
    output logic        alu_zout,
    output logic        branch_taken,
    output logic [31:0] result_q,
    output logic        zero_q,
    output logic        reg_write_q,
    output logic [4:0]  addr_in_q
);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_NOR = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               is_rtype;
    logic               is_beq;
    logic               is_bne;
    logic               zero_ext;
    logic [31:0]        imm_ext;
    logic [31:0]        alu_in2;
    logic signed [31:0] in1_s;
    logic signed [31:0] in2_s;

    assign opcode   = instruction[31:26];
    assign funct    = instruction[5:0];
    assign addr_a   = instruction[25:21];
    assign addr_b   = instruction[20:16];
    assign shamt    = instruction[10:6];
    assign imm16    = instruction[15:0];
    assign addr26   = instruction[25:0];
    assign is_rtype = (opcode == OP_RTYPE);

    // Destination is rd for R-type, rt otherwise; register 0 is not filtered here.
    assign addr_in  = is_rtype ? instruction[15:11] : instruction[20:16];

    // Decode opcode/funct into control strobes and the ALU operation.
    always_comb begin
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        is_jump   = 1'b0;
        illegal   = 1'b0;
        zero_ext  = 1'b0;
        alu_op    = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                reg_write = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    default: begin
                        reg_write = 1'b0;
                        illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin reg_write = 1'b1; alu_op = ALU_ADD; end
            OP_ANDI: begin reg_write = 1'b1; alu_op = ALU_AND; zero_ext = 1'b1; end
            OP_ORI:  begin reg_write = 1'b1; alu_op = ALU_OR;  zero_ext = 1'b1; end
            OP_SLTI: begin reg_write = 1'b1; alu_op = ALU_SLT; end
            OP_LW:   begin reg_write = 1'b1; mem_read = 1'b1; alu_op = ALU_ADD; end
            OP_SW:   begin mem_write = 1'b1; alu_op = ALU_ADD; end
            OP_BEQ:  begin is_beq = 1'b1; alu_op = ALU_SUB; end
            OP_BNE:  begin is_bne = 1'b1; alu_op = ALU_SUB; end
            OP_J:    is_jump = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    assign is_branch = is_beq | is_bne;
    assign imm_ext   = zero_ext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
    assign alu_in2   = (is_rtype | is_beq | is_bne) ? data_b : imm_ext;
    assign in1_s     = data_a;
    assign in2_s     = alu_in2;

    // ALU: shifts always act on the rt operand by shamt.
    always_comb begin
        alu_out = 32'h0;
        case (alu_op)
            ALU_AND: alu_out = data_a & alu_in2;
            ALU_OR:  alu_out = data_a | alu_in2;
            ALU_ADD: alu_out = data_a + alu_in2;
            ALU_SLL: alu_out = data_b << shamt;
            ALU_SRL: alu_out = data_b >> shamt;
            ALU_NOR: alu_out = ~(data_a | alu_in2);
            ALU_SUB: alu_out = data_a - alu_in2;
            ALU_SLT: alu_out = {31'd0, (in1_s < in2_s)};
            default: alu_out = 32'h0;
        endcase
    end

    assign alu_zout     = (alu_out == 32'h0);
    assign branch_taken = (is_beq & alu_zout) | (is_bne & ~alu_zout);

    // Execute result register for writeback; cleared while reset is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= 32'h0;
            zero_q      <= 1'b0;
            reg_write_q <= 1'b0;
            addr_in_q   <= 5'd0;
        end else begin
            result_q    <= alu_out;
            zero_q      <= alu_zout;
            reg_write_q <= reg_write;
            addr_in_q   <= addr_in;
        end
    end

endmodule

// File: tb/tb_mips_decode_execute.sv
// Self-checking bench for mips_decode_execute: directed cases plus a
// randomized run against an instruction-level reference model.
module tb_mips_decode_execute;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic [31:0] data_a = 32'h0;
    logic [31:0] data_b = 32'h0;
    logic [4:0]  addr_a, addr_b, addr_in, shamt, addr_in_q;
    logic [15:0] imm16;
    logic [25:0] addr26;
    logic        reg_write, mem_read, mem_write, is_branch, is_jump, illegal;
    logic [2:0]  alu_op;
    logic [31:0] alu_out, result_q;
    logic        alu_zout, branch_taken, zero_q, reg_write_q;

    int total = 0;
    int bad = 0;

    mips_decode_execute dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction),
        .data_a(data_a), .data_b(data_b),
        .addr_a(addr_a), .addr_b(addr_b), .addr_in(addr_in), .shamt(shamt),
        .imm16(imm16), .addr26(addr26),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .is_branch(is_branch), .is_jump(is_jump), .illegal(illegal),
        .alu_op(alu_op), .alu_out(alu_out), .alu_zout(alu_zout),
        .branch_taken(branch_taken), .result_q(result_q), .zero_q(zero_q),
        .reg_write_q(reg_write_q), .addr_in_q(addr_in_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  dst;
        logic        rw, mr, mw, br, jmp, ill, taken;
        logic [2:0]  op;
        logic [31:0] res;
        logic        chk_res;
    } exp_t;

    // Instruction-level semantics: what each mnemonic computes.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [5:0]  opc = ins[31:26];
        logic [5:0]  fn  = ins[5:0];
        logic [4:0]  rt  = ins[20:16];
        logic [4:0]  rd  = ins[15:11];
        int unsigned sh  = ins[10:6];
        logic [31:0] sx  = {{16{ins[15]}}, ins[15:0]};
        logic [31:0] zx  = {16'h0, ins[15:0]};
        e.dst = 5'd0; e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jmp = 0;
        e.ill = 0; e.taken = 0; e.op = 3'd2; e.res = 32'h0; e.chk_res = 1;
        case (opc)
            6'h00: begin
                e.rw = 1; e.dst = rd;
                case (fn)
                    6'h20: begin e.op = 3'd2; e.res = a + b; end
                    6'h22: begin e.op = 3'd6; e.res = a - b; end
                    6'h24: begin e.op = 3'd0; e.res = a & b; end
                    6'h25: begin e.op = 3'd1; e.res = a | b; end
                    6'h27: begin e.op = 3'd5; e.res = ~(a | b); end
                    6'h2A: begin e.op = 3'd7; e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                    6'h00: begin e.op = 3'd3; e.res = b << sh; end
                    6'h02: begin e.op = 3'd4; e.res = b >> sh; end
                    default: begin e.rw = 0; e.ill = 1; e.res = a + b; end
                endcase
            end
            6'h08: begin e.rw = 1; e.dst = rt; e.op = 3'd2; e.res = a + sx; end
            6'h0C: begin e.rw = 1; e.dst = rt; e.op = 3'd0; e.res = a & zx; end
            6'h0D: begin e.rw = 1; e.dst = rt; e.op = 3'd1; e.res = a | zx; end
            6'h0A: begin e.rw = 1; e.dst = rt; e.op = 3'd7; e.res = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; end
            6'h23: begin e.rw = 1; e.dst = rt; e.mr = 1; e.op = 3'd2; e.res = a + sx; end
            6'h2B: begin e.mw = 1; e.op = 3'd2; e.res = a + sx; end
            6'h04: begin e.br = 1; e.op = 3'd6; e.res = a - b; e.taken = (a == b); end
            6'h05: begin e.br = 1; e.op = 3'd6; e.res = a - b; e.taken = (a != b); end
            6'h02: begin e.jmp = 1; e.chk_res = 0; end
            default: begin e.ill = 1; e.res = a + sx; end
        endcase
        return e;
    endfunction

    // Apply inputs on the falling edge and let them settle.
    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        instruction = ins;
        data_a = a;
        data_b = b;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(32'h00221820, 32'd5, 32'd7);
        @(posedge clk); #1;
        total++;
        if (result_q !== 32'h0 || zero_q !== 1'b0 || reg_write_q !== 1'b0 || addr_in_q !== 5'd0) begin
            bad++;
            $display("FAIL reset_state got res=%h z=%b rw=%b dst=%0d exp all zero", result_q, zero_q, reg_write_q, addr_in_q);
        end
        total++;
        if (alu_out !== 32'd12) begin
            bad++;
            $display("FAIL reset_comb got alu_out=%h exp 0000000c", alu_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        drive(32'h00221820, 32'd5, 32'd7);
        total++;
        if (alu_out !== 32'd12 || addr_in !== 5'd3 || reg_write !== 1'b1) begin
            bad++;
            $display("FAIL add_comb got alu=%h dst=%0d rw=%b exp 0000000c 3 1", alu_out, addr_in, reg_write);
        end
        @(posedge clk); #1;
        total++;
        if (result_q !== 32'd12 || addr_in_q !== 5'd3 || reg_write_q !== 1'b1) begin
            bad++;
            $display("FAIL add_reg got res=%h dst=%0d rw=%b exp 0000000c 3 1", result_q, addr_in_q, reg_write_q);
        end
    endtask

    task automatic test_branch();
        drive(32'h10220010, 32'h1234, 32'h1234);
        total++;
        if (alu_zout !== 1'b1 || branch_taken !== 1'b1 || reg_write !== 1'b0 || is_branch !== 1'b1 || alu_op !== 3'b110) begin
            bad++;
            $display("FAIL beq got z=%b tk=%b rw=%b br=%b op=%b exp 1 1 0 1 110", alu_zout, branch_taken, reg_write, is_branch, alu_op);
        end
        drive(32'h14220010, 32'h1234, 32'h1234);
        total++;
        if (branch_taken !== 1'b0 || is_branch !== 1'b1 || reg_write !== 1'b0) begin
            bad++;
            $display("FAIL bne_eq got tk=%b br=%b rw=%b exp 0 1 0", branch_taken, is_branch, reg_write);
        end
        drive(32'h14220010, 32'h1234, 32'h1235);
        total++;
        if (branch_taken !== 1'b1 || alu_zout !== 1'b0) begin
            bad++;
            $display("FAIL bne_ne got tk=%b z=%b exp 1 0", branch_taken, alu_zout);
        end
    endtask

    task automatic test_extension();
        drive(32'h2024FFFF, 32'd1, 32'hDEADBEEF);
        total++;
        if (alu_out !== 32'h0 || alu_zout !== 1'b1 || addr_in !== 5'd4) begin
            bad++;
            $display("FAIL addi_sext got alu=%h z=%b dst=%0d exp 00000000 1 4", alu_out, alu_zout, addr_in);
        end
        drive(32'h3424FFFF, 32'd0, 32'hDEADBEEF);
        total++;
        if (alu_out !== 32'h0000FFFF) begin
            bad++;
            $display("FAIL ori_zext got alu=%h exp 0000ffff", alu_out);
        end
    endtask

    task automatic test_slt_shift();
        drive(32'h0022182A, 32'hFFFFFFFF, 32'd1);
        total++;
        if (alu_out !== 32'd1) begin
            bad++;
            $display("FAIL slt_signed got alu=%h exp 00000001", alu_out);
        end
        drive(32'h00021FC0, 32'h0, 32'd1);
        total++;
        if (alu_out !== 32'h80000000 || shamt !== 5'd31) begin
            bad++;
            $display("FAIL sll31 got alu=%h sh=%0d exp 80000000 31", alu_out, shamt);
        end
        drive(32'h00021FC2, 32'h0, 32'h80000000);
        total++;
        if (alu_out !== 32'd1) begin
            bad++;
            $display("FAIL srl31 got alu=%h exp 00000001", alu_out);
        end
    endtask

    task automatic test_jump_mem_illegal();
        drive(32'h08000010, 32'h0, 32'h0);
        total++;
        if (is_jump !== 1'b1 || addr26 !== 26'h10 || reg_write !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            bad++;
            $display("FAIL jump got j=%b a26=%h rw=%b mr=%b mw=%b exp 1 0000010 0 0 0", is_jump, addr26, reg_write, mem_read, mem_write);
        end
        drive(32'h8C250004, 32'h100, 32'h0);
        total++;
        if (mem_read !== 1'b1 || addr_in !== 5'd5 || reg_write !== 1'b1 || alu_out !== 32'h104) begin
            bad++;
            $display("FAIL lw got mr=%b dst=%0d rw=%b alu=%h exp 1 5 1 00000104", mem_read, addr_in, reg_write, alu_out);
        end
        drive(32'hFC000000, 32'h1, 32'h2);
        total++;
        if (illegal !== 1'b1 || reg_write !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
            is_branch !== 1'b0 || is_jump !== 1'b0 || alu_op !== 3'b010) begin
            bad++;
            $display("FAIL illegal got ill=%b rw=%b mr=%b mw=%b br=%b j=%b op=%b exp 1 0 0 0 0 0 010",
                     illegal, reg_write, mem_read, mem_write, is_branch, is_jump, alu_op);
        end
    endtask

    task automatic test_async_reset();
        drive(32'h00221820, 32'd5, 32'd7);
        @(posedge clk); #1;
        total++;
        if (result_q !== 32'd12) begin
            bad++;
            $display("FAIL areset_pre got res=%h exp 0000000c", result_q);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (result_q !== 32'h0 || reg_write_q !== 1'b0 || addr_in_q !== 5'd0) begin
            bad++;
            $display("FAIL areset_now got res=%h rw=%b dst=%0d exp 0 0 0", result_q, reg_write_q, addr_in_q);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (result_q !== 32'h0 || reg_write_q !== 1'b0 || alu_out !== 32'd12) begin
            bad++;
            $display("FAIL areset_hold got res=%h rw=%b alu=%h exp 0 0 0000000c", result_q, reg_write_q, alu_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (result_q !== 32'd12 || reg_write_q !== 1'b1 || addr_in_q !== 5'd3) begin
            bad++;
            $display("FAIL areset_release got res=%h rw=%b dst=%0d exp 0000000c 1 3", result_q, reg_write_q, addr_in_q);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [10] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
        logic [5:0] fns [8]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02};
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ins, a, b;
            logic [5:0]  opc, fn;
            exp_t e;
            ins = $urandom;
            opc = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            fn  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
            ins[31:26] = opc;
            if (opc == 6'h00) ins[5:0] = fn;
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            e = model(ins, a, b);
            drive(ins, a, b);
            total++;
            if ({addr_a, addr_b, shamt, imm16, addr26} !== {ins[25:21], ins[20:16], ins[10:6], ins[15:0], ins[25:0]}) begin
                bad++;
                $display("FAIL rnd_fields i=%0d ins=%h got a=%0d b=%0d sh=%0d imm=%h a26=%h", i, ins, addr_a, addr_b, shamt, imm16, addr26);
            end
            total++;
            if ({reg_write, mem_read, mem_write, is_branch, is_jump, illegal, branch_taken} !==
                {e.rw, e.mr, e.mw, e.br, e.jmp, e.ill, e.taken}) begin
                bad++;
                $display("FAIL rnd_ctrl i=%0d ins=%h got=%b exp=%b", i, ins,
                         {reg_write, mem_read, mem_write, is_branch, is_jump, illegal, branch_taken},
                         {e.rw, e.mr, e.mw, e.br, e.jmp, e.ill, e.taken});
            end
            if (e.rw) begin
                total++;
                if (addr_in !== e.dst) begin
                    bad++;
                    $display("FAIL rnd_dst i=%0d ins=%h got=%0d exp=%0d", i, ins, addr_in, e.dst);
                end
            end
            if (e.chk_res) begin
                total++;
                if (alu_out !== e.res || alu_zout !== (e.res == 32'h0) || alu_op !== e.op) begin
                    bad++;
                    $display("FAIL rnd_alu i=%0d ins=%h a=%h b=%h got=%h z=%b op=%b exp=%h op=%b",
                             i, ins, a, b, alu_out, alu_zout, alu_op, e.res, e.op);
                end
            end
            @(posedge clk); #1;
            total++;
            if (reg_write_q !== e.rw || (e.rw && addr_in_q !== e.dst)) begin
                bad++;
                $display("FAIL rnd_regctl i=%0d got rw=%b dst=%0d exp rw=%b dst=%0d", i, reg_write_q, addr_in_q, e.rw, e.dst);
            end
            if (e.chk_res) begin
                total++;
                if (result_q !== e.res || zero_q !== (e.res == 32'h0)) begin
                    bad++;
                    $display("FAIL rnd_regres i=%0d got=%h z=%b exp=%h", i, result_q, zero_q, e.res);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_extension();
        test_slt_shift();
        test_jump_mem_illegal();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
